// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction in flight.
// Define MEM_ARB_FAIR_EN to let IF win after MAX_STREAK back-to-back LSU grants while IF waits.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            lsu_req,
    input  logic            lsu_we,
    input  logic [AW-1:0]   lsu_addr,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_be,
    output logic            lsu_gnt,
    output logic            lsu_rvalid,
    output logic [DW-1:0]   lsu_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_n
);
    // Handshake: a request is accepted in the cycle mem_req & mem_gnt (the owner's *_gnt pulses
    // then); requesters hold req and fields until *_gnt; exactly one *_rvalid pulse follows later.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IF  = 2'd1,
        WAIT_LSU = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   sel_lsu;

    if ((DW % 8) != 0 || MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_param_check
        $error("mem_port_arbiter: DW must be a multiple of 8 and MAX_STREAK within 1..15");
    end

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] streak_q, streak_d;

    // Counts LSU grants that overtook a waiting IF request; any IF grant restarts it.
    always_comb begin
        streak_d = streak_q;
        if (if_gnt) begin
            streak_d = 4'd0;
        end else if (lsu_gnt) begin
            streak_d = if_req ? streak_q + 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign sel_lsu = lsu_req && !(if_req && streak_q == 4'(MAX_STREAK));
`else
    assign sel_lsu = lsu_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        if_gnt     = 1'b0;
        lsu_gnt    = 1'b0;
        if_rvalid  = 1'b0;
        if_rdata   = '0;
        lsu_rvalid = 1'b0;
        lsu_rdata  = '0;
        unique case (state_q)
            IDLE: begin
                // mem_rvalid is deliberately ignored here: nothing is outstanding.
                if (sel_lsu) begin
                    mem_req   = 1'b1;
                    mem_we    = lsu_we;
                    mem_addr  = lsu_addr;
                    mem_wdata = lsu_wdata;
                    mem_be    = lsu_be;
                    if (mem_gnt) begin
                        lsu_gnt = 1'b1;
                        state_d = WAIT_LSU;
                    end
                end else if (if_req) begin
                    mem_req  = 1'b1;
                    mem_addr = if_addr;
                    mem_be   = '1;
                    if (mem_gnt) begin
                        if_gnt  = 1'b1;
                        state_d = WAIT_IF;
                    end
                end
            end
            WAIT_IF: begin
                if (mem_rvalid) begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                    state_d   = IDLE;
                end
            end
            WAIT_LSU: begin
                if (mem_rvalid) begin
                    lsu_rvalid = 1'b1;
                    lsu_rdata  = mem_rdata;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_n = !((lsu_req && !lsu_gnt)
                    || (state_q == WAIT_LSU && !mem_rvalid)
                    || (if_req && !if_gnt && state_q != WAIT_IF));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grants and responses
// into queues; a monitor pops and compares whenever the DUT shows a grant or response.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          lsu_req;
    logic          lsu_we;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [3:0]    lsu_be;
    logic          lsu_gnt;
    logic          lsu_rvalid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          stall_n;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_be(lsu_be), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall_n(stall_n)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int unsigned cyc;
        bit          lsu;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } gnt_t;

    typedef struct {
        int unsigned cyc;
        bit          chk;
        logic [31:0] data;
    } rsp_t;

    gnt_t exp_gnt_q[$];
    rsp_t exp_if_q[$];
    rsp_t exp_lsu_q[$];

    int unsigned checks;
    int unsigned failures;
    int unsigned cyc;

    // Transaction-level model of the shared memory port.
    bit          busy;
    bit          owner_lsu;
    bit          own_we;
    logic [31:0] own_addr;
    int          lat;
    int          streak;
    bit          if_pend;
    bit          lsu_pend;
    logic [31:0] mem_model [16];

    bit          exp_stall;
    bit          exp_mem_req;
    logic [31:0] exp_mem_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    // mode: 0 hold pending only, 1 random, 2 both always, 3 LSU only, 4 IF only
    task automatic drive_cycle(input int mode, input int gnt_pct, input int lat_lo,
                               input int lat_hi, input int stray_pct);
        bit   was_busy;
        bit   pick_lsu;
        bit   any_req;
        bit   g_if;
        bit   g_lsu;
        gnt_t g;
        rsp_t r;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        if (!if_pend) begin
            if (mode == 2 || mode == 4) if_req = 1'b1;
            else if (mode == 1)         if_req = ($urandom_range(0, 99) < 45);
            else                        if_req = 1'b0;
            if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if_pend = if_req;
        end
        if (!lsu_pend) begin
            if (mode == 2 || mode == 3) lsu_req = 1'b1;
            else if (mode == 1)         lsu_req = ($urandom_range(0, 99) < 45);
            else                        lsu_req = 1'b0;
            lsu_we    = 1'($urandom_range(0, 1));
            lsu_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            lsu_wdata = $urandom;
            lsu_be    = 4'($urandom_range(0, 15));
            lsu_pend  = lsu_req;
        end
        mem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        was_busy   = busy;

        if (busy) begin
            if (lat == 0) begin
                mem_rvalid = 1'b1;
                if (!own_we) mem_rdata = mem_model[own_addr[5:2]];
                r.cyc  = cyc;
                r.chk  = !own_we;
                r.data = mem_rdata;
                if (owner_lsu) exp_lsu_q.push_back(r);
                else           exp_if_q.push_back(r);
                busy = 1'b0;
            end else begin
                lat--;
            end
        end else if ($urandom_range(0, 99) < stray_pct) begin
            mem_rvalid = 1'b1;
        end

        g_if     = 1'b0;
        g_lsu    = 1'b0;
        pick_lsu = lsu_req;
`ifdef MEM_ARB_FAIR_EN
        if (if_req && streak == MAX) pick_lsu = 1'b0;
`endif
        any_req      = if_req || lsu_req;
        exp_mem_req  = !was_busy && any_req;
        exp_mem_addr = pick_lsu ? lsu_addr : if_addr;

        if (!was_busy && any_req && mem_gnt) begin
            g.cyc = cyc;
            if (pick_lsu) begin
                g_lsu   = 1'b1;
                g.lsu   = 1'b1;
                g.we    = lsu_we;
                g.addr  = lsu_addr;
                g.wdata = lsu_wdata;
                g.be    = lsu_be;
                if (lsu_we) begin
                    for (int b = 0; b < 4; b++)
                        if (lsu_be[b]) mem_model[lsu_addr[5:2]][8*b +: 8] = lsu_wdata[8*b +: 8];
                end
                streak    = if_req ? streak + 1 : 0;
                owner_lsu = 1'b1;
                own_we    = lsu_we;
                own_addr  = lsu_addr;
                lsu_pend  = 1'b0;
            end else begin
                g_if      = 1'b1;
                g.lsu     = 1'b0;
                g.we      = 1'b0;
                g.addr    = if_addr;
                g.wdata   = '0;
                g.be      = 4'hf;
                streak    = 0;
                owner_lsu = 1'b0;
                own_we    = 1'b0;
                own_addr  = if_addr;
                if_pend   = 1'b0;
            end
            exp_gnt_q.push_back(g);
            busy = 1'b1;
            lat  = $urandom_range(lat_lo, lat_hi);
        end

        exp_stall = !((lsu_req && !g_lsu)
                   || (was_busy && owner_lsu && !mem_rvalid)
                   || (if_req && !g_if && !(was_busy && !owner_lsu)));
    endtask

    task automatic apply_reset(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cyc++;
            rst_n      = 1'b0;
            if_req     = 1'b0;
            lsu_req    = 1'b0;
            if_addr    = $urandom;
            lsu_addr   = $urandom;
            lsu_wdata  = $urandom;
            lsu_be     = 4'($urandom_range(0, 15));
            lsu_we     = 1'($urandom_range(0, 1));
            mem_gnt    = 1'($urandom_range(0, 1));
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            busy       = 1'b0;
            streak     = 0;
            if_pend    = 1'b0;
            lsu_pend   = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (busy || if_pend || lsu_pend); i++)
            drive_cycle(0, 100, 0, 0, 0);
        chk("drain_done", {62'd0, busy, if_pend || lsu_pend}, 64'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        gnt_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk("reset_outputs", {53'd0, mem_req, mem_we, if_gnt, lsu_gnt, if_rvalid,
                    lsu_rvalid, |mem_addr, |mem_wdata, |mem_be, |if_rdata, |lsu_rdata}, 64'd0);
                chk("reset_stall_n", stall_n, 1);
            end else begin
                chk("stall_n", stall_n, exp_stall);
                chk("mem_req", mem_req, exp_mem_req);
                if (exp_mem_req) chk("mem_addr", mem_addr, exp_mem_addr);
                if (!if_rvalid)  chk("if_rdata_idle", if_rdata, 0);
                if (!lsu_rvalid) chk("lsu_rdata_idle", lsu_rdata, 0);
                if (if_gnt || lsu_gnt) begin
                    chk("single_gnt", if_gnt && lsu_gnt, 0);
                    if (exp_gnt_q.size() == 0) begin
                        chk("gnt_unexpected", 1, 0);
                    end else begin
                        g = exp_gnt_q.pop_front();
                        chk("gnt_cycle", cyc, g.cyc);
                        chk("gnt_owner", lsu_gnt, g.lsu);
                        chk("gnt_mem_we", mem_we, g.we);
                        chk("gnt_mem_addr", mem_addr, g.addr);
                        chk("gnt_mem_be", mem_be, g.be);
                        if (g.we) chk("gnt_mem_wdata", mem_wdata, g.wdata);
                    end
                end
                if (if_rvalid) begin
                    if (exp_if_q.size() == 0) begin
                        chk("if_rvalid_unexpected", 1, 0);
                    end else begin
                        r = exp_if_q.pop_front();
                        chk("if_rvalid_cycle", cyc, r.cyc);
                        chk("if_rdata", if_rdata, r.data);
                    end
                end
                if (lsu_rvalid) begin
                    if (exp_lsu_q.size() == 0) begin
                        chk("lsu_rvalid_unexpected", 1, 0);
                    end else begin
                        r = exp_lsu_q.pop_front();
                        chk("lsu_rvalid_cycle", cyc, r.cyc);
                        if (r.chk) chk("lsu_rdata", lsu_rdata, r.data);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        busy      = 1'b0;
        owner_lsu = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        lat       = 0;
        streak    = 0;
        if_pend   = 1'b0;
        lsu_pend  = 1'b0;
        exp_stall = 1'b1;
        exp_mem_req  = 1'b0;
        exp_mem_addr = '0;
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        rst_n      = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        lsu_req    = 1'b0;
        lsu_we     = 1'b0;
        lsu_addr   = '0;
        lsu_wdata  = '0;
        lsu_be     = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        apply_reset(3);

        // single IF read with one-cycle memory latency
        drive_cycle(4, 100, 0, 0, 0);
        drive_cycle(0, 100, 0, 0, 0);
        drive_cycle(0, 100, 0, 0, 0);

        // backpressure: memory refuses three cycles, accepts on the fourth
        repeat (3) drive_cycle(4, 0, 0, 0, 0);
        drive_cycle(4, 100, 0, 0, 0);
        drain();

        // contention with latency 1
        drive_cycle(2, 100, 0, 0, 0);
        repeat (3) drive_cycle(0, 100, 0, 0, 0);
        drain();

        // randomized traffic with backpressure, variable latency and stray responses
        repeat (1500) drive_cycle(1, 70, 0, 3, 5);
        drain();

        // both requesters continuously high
        repeat (60) drive_cycle(2, 100, 0, 0, 0);
        drain();

        // reset while an LSU transaction is outstanding, then a late response
        drive_cycle(3, 100, 1, 2, 0);
        drive_cycle(0, 100, 1, 2, 0);
        apply_reset(1);
        drive_cycle(0, 100, 0, 0, 100);
        drive_cycle(4, 100, 0, 0, 0);
        drain();

        repeat (2) drive_cycle(0, 100, 0, 0, 0);
        @(negedge clk);
        #5;
        chk("gnt_queue_empty", exp_gnt_q.size(), 0);
        chk("if_queue_empty", exp_if_q.size(), 0);
        chk("lsu_queue_empty", exp_lsu_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
